// File: rtl/tkeep_to_len.sv
// Byte-enable mask to "valid bytes minus one" length code, with flags for
// all-zero and non-contiguous masks. One registered stage, no other state.
module tkeep_to_len #(
    parameter int unsigned  TKEEP_WIDTH = 8,
    localparam int unsigned LEN_W       = $clog2(TKEEP_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [TKEEP_WIDTH-1:0] tkeep,
    output logic [LEN_W-1:0]       len,
    output logic                   tkeep_zero,
    output logic                   tkeep_malformed
);

    logic [LEN_W:0]       pop_cnt;
    logic [TKEEP_WIDTH-1:0] keep_inv;
    logic [TKEEP_WIDTH-1:0] lsb_probe;
    logic [TKEEP_WIDTH-1:0] msb_probe;
    logic                   lsb_aligned;
    logic                   msb_aligned;

    logic [LEN_W-1:0] len_d, len_q;
    logic             zero_d, zero_q;
    logic             mal_d, mal_q;

    // Balanced adder tree: level l holds TKEEP_WIDTH>>l partial counts.
    for (genvar l = 0; l <= LEN_W; l++) begin : g_lvl
        localparam int unsigned CNT = TKEEP_WIDTH >> l;
        logic [LEN_W:0] sum [CNT];
        for (genvar j = 0; j < CNT; j++) begin : g_node
            if (l == 0) begin : g_leaf
                assign sum[j] = {{LEN_W{1'b0}}, tkeep[j]};
            end else begin : g_add
                assign sum[j] = g_lvl[l-1].sum[2*j] + g_lvl[l-1].sum[2*j+1];
            end
        end
    end

    assign pop_cnt = g_lvl[LEN_W].sum[0];

    // A run of ones from bit 0 turns into a single carry when incremented;
    // an MSB-anchored run is the same test applied to the inverted mask.
    assign keep_inv    = ~tkeep;
    assign lsb_probe   = tkeep + TKEEP_WIDTH'(1);
    assign msb_probe   = keep_inv + TKEEP_WIDTH'(1);
    assign lsb_aligned = ((tkeep & lsb_probe) == '0);
    assign msb_aligned = ((keep_inv & msb_probe) == '0);

    always_comb begin
        zero_d = (pop_cnt == '0);
        mal_d  = !zero_d && !(lsb_aligned || msb_aligned);
        len_d  = '0;
        if (!zero_d) begin
            len_d = LEN_W'(pop_cnt - 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q  <= '0;
            zero_q <= 1'b0;
            mal_q  <= 1'b0;
        end else begin
            len_q  <= len_d;
            zero_q <= zero_d;
            mal_q  <= mal_d;
        end
    end

    assign len             = len_q;
    assign tkeep_zero      = zero_q;
    assign tkeep_malformed = mal_q;

endmodule

// File: tb/tb_tkeep_to_len.sv
// Table-driven bench for tkeep_to_len (W=8) with a scoreboard queue of
// expected results compared one cycle after each mask is driven.
module tb_tkeep_to_len;

    localparam int unsigned W  = 8;
    localparam int unsigned LW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  tkeep;
    logic [LW-1:0] len;
    logic          tkeep_zero;
    logic          tkeep_malformed;

    always #5 clk = ~clk;

    tkeep_to_len #(.TKEEP_WIDTH(W)) dut (
        .clk             (clk),
        .rst             (rst),
        .tkeep           (tkeep),
        .len             (len),
        .tkeep_zero      (tkeep_zero),
        .tkeep_malformed (tkeep_malformed)
    );

    typedef struct {
        logic [W-1:0]  tk;
        logic [LW-1:0] len;
        logic          z;
        logic          m;
    } vec_t;

    vec_t        sb_q [$];
    vec_t        tbl [$];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // Independent reference: count bits, compare against thermometer masks.
    function automatic vec_t model(input logic [W-1:0] tk);
        vec_t         e;
        int unsigned  n;
        logic [W-1:0] ones;
        logic [W-1:0] lsb_m;
        logic [W-1:0] msb_m;
        n = 0;
        for (int i = 0; i < int'(W); i++) if (tk[i]) n++;
        ones  = '1;
        lsb_m = (n == 0) ? '0 : (ones >> (W - n));
        msb_m = (n == 0) ? '0 : (ones << (W - n));
        e.tk  = tk;
        e.z   = (n == 0);
        e.len = (n == 0) ? '0 : LW'(n - 1);
        e.m   = (n != 0) && (tk != lsb_m) && (tk != msb_m);
        return e;
    endfunction

    function automatic vec_t mk(input logic [W-1:0] tk, input int unsigned l,
                                input logic z, input logic m);
        vec_t e;
        e.tk  = tk;
        e.len = LW'(l);
        e.z   = z;
        e.m   = m;
        return e;
    endfunction

    task automatic check_out();
        vec_t e;
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        n_vec++;
        if (len !== e.len || tkeep_zero !== e.z || tkeep_malformed !== e.m) begin
            n_bad++;
            $display("FAIL vec tkeep=%h: got len=%0d zero=%b mal=%b, expected len=%0d zero=%b mal=%b",
                     e.tk, len, tkeep_zero, tkeep_malformed, e.len, e.z, e.m);
        end
    endtask

    // Drive on the falling edge; the result of the previous drive is visible then.
    task automatic apply(input logic r, input logic [W-1:0] tk, input vec_t e);
        @(negedge clk);
        check_out();
        rst   = r;
        tkeep = tk;
        sb_q.push_back(e);
    endtask

    initial begin
        vec_t zr;
        zr    = mk(8'h00, 0, 1'b0, 1'b0);
        rst   = 1'b1;
        tkeep = '0;

        // MSB-aligned sweep with wrap
        tbl.push_back(mk(8'h80, 0, 0, 0));
        tbl.push_back(mk(8'hC0, 1, 0, 0));
        tbl.push_back(mk(8'hE0, 2, 0, 0));
        tbl.push_back(mk(8'hF0, 3, 0, 0));
        tbl.push_back(mk(8'hF8, 4, 0, 0));
        tbl.push_back(mk(8'hFC, 5, 0, 0));
        tbl.push_back(mk(8'hFE, 6, 0, 0));
        tbl.push_back(mk(8'hFF, 7, 0, 0));
        tbl.push_back(mk(8'h80, 0, 0, 0));
        // LSB-aligned sweep
        tbl.push_back(mk(8'h01, 0, 0, 0));
        tbl.push_back(mk(8'h03, 1, 0, 0));
        tbl.push_back(mk(8'h07, 2, 0, 0));
        tbl.push_back(mk(8'h0F, 3, 0, 0));
        tbl.push_back(mk(8'h1F, 4, 0, 0));
        tbl.push_back(mk(8'h3F, 5, 0, 0));
        tbl.push_back(mk(8'h7F, 6, 0, 0));
        tbl.push_back(mk(8'hFF, 7, 0, 0));
        // zero and malformed
        tbl.push_back(mk(8'h00, 0, 1, 0));
        tbl.push_back(mk(8'hA0, 1, 0, 1));
        tbl.push_back(mk(8'h18, 1, 0, 1));
        tbl.push_back(mk(8'h7F, 6, 0, 0));
        tbl.push_back(mk(8'h81, 1, 0, 1));
        tbl.push_back(mk(8'hFD, 6, 0, 1));
        tbl.push_back(mk(8'h02, 0, 0, 1));
        // back-to-back alternation
        tbl.push_back(mk(8'hFF, 7, 0, 0));
        tbl.push_back(mk(8'h00, 0, 1, 0));
        tbl.push_back(mk(8'hFF, 7, 0, 0));
        tbl.push_back(mk(8'h00, 0, 1, 0));
        tbl.push_back(mk(8'hFF, 7, 0, 0));

        // power-on reset state
        apply(1'b1, 8'h00, zr);
        apply(1'b1, 8'h00, zr);

        foreach (tbl[i]) apply(1'b0, tbl[i].tk, tbl[i]);

        // reset held two cycles while driving a full mask, then released
        apply(1'b1, 8'hFF, zr);
        apply(1'b1, 8'hFF, zr);
        apply(1'b0, 8'hFF, mk(8'hFF, 7, 0, 0));

        // mid-stream reset discards the in-flight malformed result
        apply(1'b0, 8'hA0, mk(8'hA0, 1, 0, 1));
        apply(1'b1, 8'h18, zr);
        apply(1'b0, 8'h18, mk(8'h18, 1, 0, 1));
        apply(1'b0, 8'h00, mk(8'h00, 0, 1, 0));

        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] r;
            r = W'($urandom_range(0, 255));
            apply(1'b0, r, model(r));
        end

        @(negedge clk);
        check_out();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
